// File: rtl/decimal_keypad_encoder.sv
// Decimal keypad encoder: debounces a 10-line one-hot keypad into BCD digits and collects up to four of them.
// Latency: key_valid is high for one cycle, DEBOUNCE_CYCLES edges after a clean press first appears.
// Backpressure: out_valid, out_bcd and out_count hold until out_ready is taken. Keys, enter and clr are ignored while they wait.
module decimal_keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  key,
  input  logic        enter,
  input  logic        clr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_bcd,
  output logic [2:0]  out_count,
  output logic        key_valid,
  output logic [3:0]  key_bcd,
  output logic        multi_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_OUT      = 2'd3
  } state_t;

  // Sample count that completes a debounce. The legal range 2..255 fits in the 8-bit counter.
  localparam logic [7:0] DB_TARGET = 8'(DEBOUNCE_CYCLES);

  state_t      r_state;
  logic [7:0]  r_cnt;        // consecutive identical samples seen so far
  logic [9:0]  r_latched;    // key pattern under debounce
  logic [15:0] r_buf;        // entered digits, newest in [3:0]
  logic [2:0]  r_count;      // digits held in r_buf, 0..4
  logic        r_out_valid;
  logic [15:0] r_out_bcd;
  logic [2:0]  r_out_count;
  logic        r_key_valid;
  logic [3:0]  r_key_bcd;
  logic        r_multi_err;

  logic        w_key_zero;
  logic        w_key_onehot;
  logic        w_key_multi;
  logic        w_key_same;
  logic [3:0]  w_key_code;
  logic [7:0]  w_cnt_next;
  logic        w_accept;
  logic        w_enter_take;
  logic [15:0] w_buf_shift;
  logic [2:0]  w_count_inc;

  // Classify the current key sample. Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign w_key_zero   = (key == 10'd0);
  assign w_key_onehot = !w_key_zero && ((key & (key - 10'd1)) == 10'd0);
  assign w_key_multi  = !w_key_zero && !w_key_onehot;
  assign w_key_same   = (key == r_latched);

  // Debounce progress. The new count is compared, so the first sample counts as one.
  assign w_cnt_next   = r_cnt + 8'd1;
  assign w_accept     = w_key_same && (w_cnt_next == DB_TARGET);

  // enter only counts when there is at least one digit to send.
  assign w_enter_take = enter && (r_count != 3'd0);

  // Digit buffer after an accept. The oldest digit falls off the top once four are held.
  assign w_buf_shift  = {r_buf[11:0], w_key_code};
  assign w_count_inc  = (r_count == 3'd4) ? 3'd4 : (r_count + 3'd1);

  // Encode the one-hot key lines to BCD. Bit k gives code k.
  always_comb begin
    w_key_code = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (key[k]) begin
        w_key_code = 4'(k);
      end
    end
  end

  // Keypad FSM: priority is reset, then the output hold, then clr, then enter, then key handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_latched   <= 10'd0;
      r_buf       <= 16'd0;
      r_count     <= 3'd0;
      r_out_valid <= 1'b0;
      r_out_bcd   <= 16'd0;
      r_out_count <= 3'd0;
      r_key_valid <= 1'b0;
      r_key_bcd   <= 4'd0;
      r_multi_err <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_multi_err <= 1'b0;

      if (r_state == S_OUT) begin
        // Hold the result until it is taken. A key still down then goes to HELD, so it is not entered twice.
        if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= w_key_zero ? S_IDLE : S_HELD;
        end
      end else if (clr) begin
        r_buf     <= 16'd0;
        r_count   <= 3'd0;
        r_cnt     <= 8'd0;
        r_latched <= 10'd0;
        r_state   <= S_IDLE;
      end else if (w_enter_take) begin
        // The snapshot wins over a same-cycle accept. That pending key is dropped.
        r_out_bcd   <= r_buf;
        r_out_count <= r_count;
        r_out_valid <= 1'b1;
        r_buf       <= 16'd0;
        r_count     <= 3'd0;
        r_cnt       <= 8'd0;
        r_latched   <= 10'd0;
        r_state     <= S_OUT;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_key_onehot) begin
              r_latched <= key;
              r_cnt     <= 8'd1;
              r_state   <= S_DEBOUNCE;
            end else if (w_key_multi) begin
              r_multi_err <= 1'b1;
            end
          end

          S_DEBOUNCE: begin
            if (w_key_same) begin
              if (w_accept) begin
                r_buf       <= w_buf_shift;
                r_count     <= w_count_inc;
                r_key_bcd   <= w_key_code;
                r_key_valid <= 1'b1;
                r_cnt       <= 8'd0;
                r_state     <= S_HELD;
              end else begin
                r_cnt <= w_cnt_next;
              end
            end else if (w_key_zero) begin
              r_cnt   <= 8'd0;
              r_state <= S_IDLE;
            end else if (w_key_onehot) begin
              r_latched <= key;
              r_cnt     <= 8'd1;
            end else begin
              r_cnt       <= 8'd0;
              r_multi_err <= 1'b1;
              r_state     <= S_IDLE;
            end
          end

          S_HELD: begin
            if (w_key_zero) begin
              r_state <= S_IDLE;
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;
  assign out_count = r_out_count;
  assign key_valid = r_key_valid;
  assign key_bcd   = r_key_bcd;
  assign multi_err = r_multi_err;

endmodule

// File: doc/decimal_keypad_encoder.md
DECIMAL_KEYPAD_ENCODER -- requirements
Module: decimal_keypad_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, legal range 2..255: consecutive identical samples required to accept a key.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port key  input  10  decimal key lines, bit k = key k pressed, legal press one-hot.
REQ-005 The block SHALL have port enter  input  1  level, request to emit the entered number.
REQ-006 The block SHALL have port clr  input  1  level, discard entered digits.
REQ-007 The block SHALL have port out_ready  input  1  consumer ready.
REQ-008 The block SHALL have port out_valid  output  1  entered number available.
REQ-009 The block SHALL have port out_bcd  output  16  four BCD digits, [3:0] most recent digit.
REQ-010 The block SHALL have port out_count  output  3  digits in out_bcd, 1..4.
REQ-011 The block SHALL have port key_valid  output  1  one-cycle pulse per accepted key.
REQ-012 The block SHALL have port key_bcd  output  4  BCD code of the last accepted key, 0..9.
REQ-013 The block SHALL have port multi_err  output  1  one-cycle pulse on a multi-key sample.

Function
REQ-014 The block SHALL use FSM states IDLE, DEBOUNCE, HELD, OUT; all outputs registered.
REQ-015 Encoding SHALL map key bit k to BCD k (4'd0..4'd9).
REQ-016 IDLE: one-hot key -> latch key, cnt=1, go DEBOUNCE; key==0 -> stay; multi-bit key -> stay, pulse multi_err.
REQ-017 DEBOUNCE, key equal to latched: cnt+1; when the new count reaches DEBOUNCE_CYCLES -> accept, go HELD.
REQ-018 DEBOUNCE, key changed: zero -> IDLE; other one-hot -> re-latch, cnt=1; multi-bit -> IDLE, pulse multi_err.
REQ-019 On accept, the digit buffer SHALL shift left one digit with the new code in [3:0]; key_bcd SHALL update and key_valid SHALL pulse high for exactly one cycle after the accepting edge.
REQ-020 Digit count SHALL saturate at 4: the fifth and later digits shift out the oldest digit and count stays 4.
REQ-021 HELD: stay while key!=0; key==0 on one sample -> IDLE; a new press requires release first.
REQ-022 enter sampled high in IDLE/DEBOUNCE/HELD with count>0 -> out_bcd/out_count = buffer snapshot, out_valid=1, buffer and count cleared, go OUT.
REQ-023 enter with count==0 SHALL be ignored.
REQ-024 enter SHALL take priority over a same-cycle accept; the pending key is abandoned with no key_valid and no digit shift.
REQ-025 OUT: out_valid, out_bcd, out_count SHALL hold stable until out_valid&&out_ready on an edge.
REQ-026 After the OUT transfer edge, out_valid=0; next state HELD if key!=0, else IDLE.
REQ-027 OUT: key, enter, clr SHALL be ignored and multi_err SHALL not pulse.
REQ-028 clr high outside OUT SHALL clear buffer and count, abandon debounce, and go IDLE.
REQ-029 clr SHALL take priority over enter and accept.
REQ-030 out_bcd/out_count SHALL retain the last transferred value while out_valid=0.

Reset
REQ-031 rst high at a clock edge SHALL force IDLE and clear buffer, count, cnt, latched key, out_valid, out_bcd, out_count, key_valid, key_bcd, multi_err to 0; it has priority over all inputs and applies mid-debounce or in OUT (pending output lost).
REQ-032 After rst deasserts, a key already held SHALL be treated as a fresh press from IDLE.

Verification
REQ-033 key=10'b0000001000 stable 4 edges, DEBOUNCE_CYCLES=4 -> key_valid one cycle after edge 4, key_bcd=3; no second pulse until release and re-press.
REQ-034 key bit 7 held 2 edges, then bit 2 held 4 edges -> exactly one key_valid with key_bcd=2.
REQ-035 Press 1,2,3,4,5 with release between each, then enter with out_ready=0 for 3 cycles -> out_valid held, out_bcd=16'h2345, out_count=4; out_ready=1 -> out_valid=0 on the next cycle.
REQ-036 key=10'b0000100001 in IDLE -> multi_err one cycle, no key_valid, state stays IDLE; enter with count 0 -> no out_valid.
REQ-037 Press 9, then enter and clr high together -> no out_valid, count 0; then press 6 and assert enter -> out_bcd=16'h0006, out_count=1.
REQ-038 rst mid-debounce and rst in OUT -> all outputs 0 on the next cycle and no key_valid.
